image_sdram_writer: RTL and testbench
=====================================

IMAGE_SDRAM_WRITER -- requirements
Module: image_sdram_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of packed-word entries buffered ahead of SDRAM (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port image_download  input  1  high while the loader is in the image region.
REQ-005 SHALL have port wr_8bit  input  1  one-cycle byte-write strobe from the loader.
REQ-006 SHALL have port addr_8bit  input  26  byte address relative to image start.
REQ-007 SHALL have port data_8bit  input  8  byte data.
REQ-008 SHALL have port sdram_req  output  1  write request, held until acknowledged.
REQ-009 SHALL have port sdram_addr  output  25  16-bit word address.
REQ-010 SHALL have port sdram_data  output  16  write data, {high byte, low byte}.
REQ-011 SHALL have port sdram_ack  input  1  one-cycle completion pulse from the SDRAM controller.
REQ-012 SHALL have port words_written  output  25  count of acknowledged words this download.
REQ-013 SHALL have port overflow  output  1  sticky; a packed word was dropped.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the download has fully drained to SDRAM.

Function
REQ-015 A byte SHALL be accepted only in a cycle with wr_8bit=1 and image_download=1; all other wr_8bit cycles are ignored.
REQ-016 Even byte (addr_8bit[0]=0): SHALL latch low byte and word address addr_8bit[25:1] and set pending.
REQ-017 Odd byte: SHALL push {addr_8bit[25:1], data_8bit, low} with low = latched byte if pending and addresses match, else 8'h00; pending cleared.
REQ-018 Even byte while pending: SHALL push the old word as {old addr, 8'h00, old low} and latch the new byte in the same cycle.
REQ-019 image_download falling edge with pending set: SHALL push {pending addr, 8'h00, low} and clear pending.
REQ-020 Push into a full FIFO SHALL drop the word and set overflow; FIFO contents are unchanged.
REQ-021 Simultaneous push and pop on a full FIFO SHALL succeed (pop frees the slot); no overflow.
REQ-022 Control FSM states: IDLE, REQ. IDLE->REQ when FIFO non-empty; sdram_req, sdram_addr, sdram_data registered from FIFO head on that transition.
REQ-023 In REQ, sdram_req/addr/data SHALL remain stable until sdram_ack=1; on ack: pop, increment words_written, sdram_req=0 next cycle, return to IDLE.
REQ-024 Minimum spacing SHALL be one IDLE cycle between consecutive requests; latency from push to sdram_req is 2 cycles with the FIFO empty and the FSM in IDLE.
REQ-025 sdram_ack while in IDLE SHALL be ignored.
REQ-026 image_download rising edge SHALL clear words_written, overflow, pending and the drain flag; the FIFO is not flushed.
REQ-027 image_download falling edge SHALL set a drain flag; done SHALL pulse one cycle when drain flag=1, pending=0, FIFO empty and FSM in IDLE, then clear the drain flag.
REQ-028 words_written SHALL wrap modulo 2^25.

Reset
REQ-029 Reset SHALL force: FSM IDLE, FIFO empty, pending=0, drain=0, sdram_req=0, sdram_addr=0, sdram_data=0, words_written=0, overflow=0, done=0.
REQ-030 Reset asserted mid-request SHALL drop sdram_req asynchronously; the in-flight word is lost.

Structure
REQ-031 FSM state enum and FIFO_DEPTH default SHALL live in the shared types package.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameterised width 41, depth FIFO_DEPTH, full/empty flags, push/pop same-cycle safe).

Verification
REQ-033 Bytes 0x34@0, 0x12@1, ack after 3 cycles -> sdram_addr=0, sdram_data=0x1234, words_written=1.
REQ-034 Byte 0xAB@4 then 0xCD@8 -> pushes {2, 0x00AB}, and at fall of image_download {4, 0x00CD}; done after both acks.
REQ-035 Odd byte 0x77@7 with no pending -> {3, 0x7700}.
REQ-036 Hold sdram_ack low, write 9 words with FIFO_DEPTH=8 -> 8 stored (one in REQ, seven queued, ninth fits only if it coincides with a pop), overflow=1, later acks drain in order.
REQ-037 Assert reset while sdram_req=1 -> sdram_req=0 same cycle, all counters 0, no done.
REQ-038 New download rising edge after overflow -> overflow=0, words_written=0.

Source files
------------

// File: rtl/image_sdram_writer_pkg.sv
// Shared types for the image SDRAM writer: control states, packed word layout, default queue depth.
package image_sdram_writer_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] data;
    } word_t;

    localparam int WORD_W = $bits(word_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags and a combinational head.
// A push while full is taken only if a pop frees the slot in the same cycle; otherwise it is discarded.
module sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_sdram_writer.sv
// Packs loader bytes into 16-bit words, queues them and issues held SDRAM write requests.
// Push-to-request latency is 2 cycles; words arriving with the queue full are dropped and flagged.
module image_sdram_writer
    import image_sdram_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        image_download,
    input  logic        wr_8bit,
    input  logic [25:0] addr_8bit,
    input  logic [7:0]  data_8bit,
    output logic        sdram_req,
    output logic [24:0] sdram_addr,
    output logic [15:0] sdram_data,
    input  logic        sdram_ack,
    output logic [24:0] words_written,
    output logic        overflow,
    output logic        done
);
    state_t      state;
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic        byte_ok;
    logic        pend;
    logic [24:0] pend_addr;
    logic [7:0]  pend_low;
    logic        drain;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    word_t       push_word;
    word_t       head_word;

    assign dl_rise = image_download && !dl_q;
    assign dl_fall = !image_download && dl_q;
    assign byte_ok = wr_8bit && image_download;
    assign pop     = (state == REQ) && sdram_ack;

    // At most one word is produced per cycle: fall-edge flushes only happen with no byte strobe.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (byte_ok && !addr_8bit[0]) begin
            push      = pend;
            push_word = '{addr: pend_addr, data: {8'h00, pend_low}};
        end else if (byte_ok) begin
            push      = 1'b1;
            push_word = '{addr: addr_8bit[25:1],
                          data: {data_8bit, (pend && pend_addr == addr_8bit[25:1]) ? pend_low : 8'h00}};
        end else if (dl_fall && pend) begin
            push      = 1'b1;
            push_word = '{addr: pend_addr, data: {8'h00, pend_low}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q      <= 1'b0;
            pend      <= 1'b0;
            pend_addr <= '0;
            pend_low  <= '0;
        end else begin
            dl_q <= image_download;
            if (dl_rise) begin
                pend <= 1'b0;
            end
            if (byte_ok && !addr_8bit[0]) begin
                pend      <= 1'b1;
                pend_addr <= addr_8bit[25:1];
                pend_low  <= data_8bit;
            end else if (byte_ok || dl_fall) begin
                pend <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sdram_req     <= 1'b0;
            sdram_addr    <= '0;
            sdram_data    <= '0;
            words_written <= '0;
            overflow      <= 1'b0;
            drain         <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= REQ;
                        sdram_req  <= 1'b1;
                        sdram_addr <= head_word.addr;
                        sdram_data <= head_word.data;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        state         <= IDLE;
                        sdram_req     <= 1'b0;
                        words_written <= words_written + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new download restarts the statistics; an overflow in that same cycle still counts.
            if (dl_rise) begin
                words_written <= '0;
                overflow      <= 1'b0;
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end

            if (dl_rise) begin
                drain <= 1'b0;
            end else if (dl_fall) begin
                drain <= 1'b1;
            end else if (drain && !pend && fifo_empty && state == IDLE) begin
                drain <= 1'b0;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_sdram_writer.sv
// Randomized scoreboard bench for image_sdram_writer with a byte-level reference model.
module tb_image_sdram_writer;
    import image_sdram_writer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        image_download;
    logic        wr_8bit;
    logic [25:0] addr_8bit;
    logic [7:0]  data_8bit;
    logic        sdram_req;
    logic [24:0] sdram_addr;
    logic [15:0] sdram_data;
    logic        sdram_ack;
    logic [24:0] words_written;
    logic        overflow;
    logic        done;

    image_sdram_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .image_download (image_download),
        .wr_8bit        (wr_8bit),
        .addr_8bit      (addr_8bit),
        .data_8bit      (data_8bit),
        .sdram_req      (sdram_req),
        .sdram_addr     (sdram_addr),
        .sdram_data     (sdram_data),
        .sdram_ack      (sdram_ack),
        .words_written  (words_written),
        .overflow       (overflow),
        .done           (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    word_t       exp_q[$];
    bit          m_pend;
    bit          m_dl;
    bit          m_ovf;
    logic [24:0] m_addr;
    logic [7:0]  m_low;
    logic [24:0] m_words;
    int          m_occ;
    int          exp_done;
    int          done_cnt;
    bit          hs_prev;
    word_t       mw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model by the same cycle.
    task automatic step(input logic wr, input logic [25:0] a, input logic [7:0] d,
                        input logic dl, input logic ack);
        bit    push_now;
        bit    pop_now;
        bit    rise;
        bit    fall;
        word_t w;
        image_download = dl;
        wr_8bit        = wr;
        addr_8bit      = a;
        data_8bit      = d;
        sdram_ack      = ack;
        rise     = dl && !m_dl;
        fall     = !dl && m_dl;
        pop_now  = ack && sdram_req;
        push_now = 0;
        w        = '0;
        if (wr && dl && !a[0]) begin
            if (m_pend) begin
                push_now = 1;
                w.addr   = m_addr;
                w.data   = {8'h00, m_low};
            end
            m_pend = 1;
            m_addr = a[25:1];
            m_low  = d;
        end else if (wr && dl) begin
            push_now = 1;
            w.addr   = a[25:1];
            w.data   = {d, (m_pend && m_addr == a[25:1]) ? m_low : 8'h00};
            m_pend   = 0;
        end else if (fall && m_pend) begin
            push_now = 1;
            w.addr   = m_addr;
            w.data   = {8'h00, m_low};
            m_pend   = 0;
        end
        if (fall) exp_done++;
        if (rise) m_ovf = 0;
        if (push_now) begin
            if (m_occ == DEPTH && !pop_now) begin
                m_ovf = 1;
            end else begin
                exp_q.push_back(w);
                m_occ++;
            end
        end
        if (pop_now) begin
            m_occ--;
            m_words = m_words + 25'd1;
        end
        if (rise) m_words = '0;
        m_dl = dl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (done_cnt != exp_done && n < budget) begin
            step(1'b0, 26'd0, 8'd0, 1'b0, 1'($urandom_range(0, 1)));
            n++;
        end
        if (done_cnt != exp_done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: done pulses %0d, wanted %0d within %0d cycles", done_cnt, exp_done, budget);
        end
        step(1'b0, 26'd0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 26'd0, 8'd0, 1'b0, 1'b0);
        chk("done_count", done_cnt, exp_done);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hs_prev = 0;
        end else begin
            if (hs_prev) chk("idle_gap", sdram_req, 0);
            hs_prev = 0;
            if (sdram_req && sdram_ack) begin
                hs_prev = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, expected none", sdram_addr, sdram_data);
                end else begin
                    mw = exp_q.pop_front();
                    chk("word_addr", sdram_addr, mw.addr);
                    chk("word_data", sdram_data, mw.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_drained", {sdram_req, 31'(exp_q.size())}, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got no end, required end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; image_download = 0; wr_8bit = 0; addr_8bit = '0; data_8bit = '0; sdram_ack = 0;
        m_pend = 0; m_dl = 0; m_ovf = 0; m_addr = '0; m_low = '0; m_words = '0; m_occ = 0;
        exp_done = 0; done_cnt = 0; hs_prev = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_data", sdram_data, 0);
        chk("rst_words", words_written, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        reset = 0;
        @(posedge clk);
        #1;

        // Simple pair, latency and held request
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 26'd0, 8'h34, 1'b1, 1'b0);
        step(1'b1, 26'd1, 8'h12, 1'b1, 1'b0);
        chk("lat_cycle1_req", sdram_req, 0);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        chk("lat_cycle2_req", sdram_req, 1);
        chk("pair_addr", sdram_addr, 25'd0);
        chk("pair_data", sdram_data, 16'h1234);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        chk("req_held", {sdram_req, sdram_addr, sdram_data}, {1'b1, 25'd0, 16'h1234});
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b1);
        chk("req_dropped", sdram_req, 0);
        chk("words_after_ack", words_written, 25'd1);

        // Lone odd byte, even-then-even, fall flush
        step(1'b1, 26'd7, 8'h77, 1'b1, 1'b0);
        step(1'b1, 26'd4, 8'hAB, 1'b1, 1'b0);
        step(1'b1, 26'd8, 8'hCD, 1'b1, 1'b0);
        step(1'b0, 26'd0, 8'h00, 1'b0, 1'b0);
        drain(400);
        chk("words_dl1", words_written, 25'd4);

        // Overflow with acks held low
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 26'(32 + 4 * i), 8'(i), 1'b1, 1'b0);
            step(1'b1, 26'(33 + 4 * i), 8'(i + 16), 1'b1, 1'b0);
        end
        chk("ovf_set", overflow, 1);
        step(1'b0, 26'd0, 8'h00, 1'b0, 1'b0);
        drain(400);
        chk("words_ovf", words_written, 25'd8);
        chk("ovf_sticky", overflow, 1);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        chk("ovf_clr_rise", overflow, 0);
        chk("words_clr_rise", words_written, 0);

        // Push into a full queue coinciding with a pop
        for (int i = 0; i < 8; i++) step(1'b1, 26'(2 * i + 1), 8'(i + 100), 1'b1, 1'b0);
        chk("full_req", sdram_req, 1);
        step(1'b1, 26'd99, 8'hEE, 1'b1, 1'b1);
        chk("ovf_push_pop", overflow, 0);
        step(1'b0, 26'd0, 8'h00, 1'b0, 1'b0);
        drain(400);
        chk("words_push_pop", words_written, 25'd9);

        // Randomized downloads
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 26'd0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 150; c++) begin
                step(1'($urandom_range(0, 2) != 0), 26'($urandom_range(0, 40)), 8'($urandom),
                     1'b1, 1'($urandom_range(0, 3) == 0));
            end
            step(1'b0, 26'd0, 8'h00, 1'b0, 1'b0);
            drain(2000);
            chk("rnd_words", words_written, m_words);
            chk("rnd_ovf", overflow, m_ovf);
        end

        // Reset during an outstanding request
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 26'd3, 8'h55, 1'b1, 1'b0);
        step(1'b1, 26'd5, 8'h66, 1'b1, 1'b0);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 26'd0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_req", sdram_req, 1);
        chk("pre_rst_words", words_written, 25'd1);
        #2;
        reset = 1;
        image_download = 0;
        sdram_ack = 0;
        #1;
        chk("rst_async_req", sdram_req, 0);
        chk("rst_async_words", words_written, 0);
        chk("rst_async_ovf", overflow, 0);
        exp_q.delete();
        m_occ = 0; m_pend = 0; m_dl = 0; m_words = '0; m_ovf = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 26'd0, 8'h00, 1'b0, 1'b0);
        chk("no_done_after_rst", done_cnt, exp_done);
        chk("idle_after_rst", {sdram_req, words_written}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
